// File: rtl/odometry_pkg.sv
// Shared constants, CORDIC arctangent table and FSM encoding
// for the odometry position update block.
package odometry_pkg;

    localparam logic signed [63:0] TWO_PI_MICRO    = 64'sd6283185;
    localparam logic signed [63:0] PI_MICRO        = 64'sd3141593;
    localparam logic signed [63:0] HALF_PI_MICRO   = 64'sd1570796;
    localparam logic signed [63:0] CORDIC_GAIN_Q16 = 64'sd39797;

    typedef enum logic [1:0] {
        IDLE,
        PREP,
        ITER,
        ACC
    } state_e;

    // atan(2^-i) in microradians
    function automatic logic signed [63:0] atan_micro(input logic [4:0] i);
        logic signed [63:0] v;
        v = 64'sd0;
        case (i)
            5'd0:    v = 64'sd785398;
            5'd1:    v = 64'sd463648;
            5'd2:    v = 64'sd244979;
            5'd3:    v = 64'sd124355;
            5'd4:    v = 64'sd62419;
            5'd5:    v = 64'sd31240;
            5'd6:    v = 64'sd15624;
            5'd7:    v = 64'sd7812;
            5'd8:    v = 64'sd3906;
            5'd9:    v = 64'sd1953;
            5'd10:   v = 64'sd977;
            5'd11:   v = 64'sd488;
            5'd12:   v = 64'sd244;
            5'd13:   v = 64'sd122;
            5'd14:   v = 64'sd61;
            5'd15:   v = 64'sd31;
            5'd16:   v = 64'sd15;
            5'd17:   v = 64'sd8;
            5'd18:   v = 64'sd4;
            5'd19:   v = 64'sd2;
            default: v = 64'sd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/cordic_rotator.sv
// Iterative rotation-mode CORDIC core: one micro-rotation per step,
// angle held in microradians.
module cordic_rotator
    import odometry_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load_i,
    input  logic               step_i,
    input  logic [4:0]         idx_i,
    input  logic signed [63:0] x0_i,
    input  logic signed [63:0] y0_i,
    input  logic signed [63:0] z0_i,
    output logic signed [63:0] x_o,
    output logic signed [63:0] y_o
);

    logic signed [63:0] x_q, y_q, z_q;
    logic signed [63:0] x_d, y_d, z_d;
    logic signed [63:0] xs, ys, at;
    logic               dpos;

    always_comb begin
        xs   = x_q >>> idx_i;
        ys   = y_q >>> idx_i;
        at   = atan_micro(idx_i);
        dpos = (z_q >= 64'sd0);
        x_d  = dpos ? x_q - ys : x_q + ys;
        y_d  = dpos ? y_q + xs : y_q - xs;
        z_d  = dpos ? z_q - at : z_q + at;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
            z_q <= '0;
        end else if (load_i) begin
            x_q <= x0_i;
            y_q <= y0_i;
            z_q <= z0_i;
        end else if (step_i) begin
            x_q <= x_d;
            y_q <= y_d;
            z_q <= z_d;
        end
    end

    assign x_o = x_q;
    assign y_o = y_q;

endmodule

// File: rtl/odometry_position_update.sv
// Rotates each odometry distance step by the heading and
// accumulates it into global x/y position (micrometres).
module odometry_position_update
    import odometry_pkg::*;
#(
    parameter int ITERATIONS = 20,
    parameter int FRAC_BITS  = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               clear_pos,
    input  logic signed [63:0] argument,
    input  logic signed [31:0] delta_dist,
    output logic signed [63:0] x_pos,
    output logic signed [63:0] y_pos,
    output logic               busy,
    output logic               done,
    output logic               range_err
);

    state_e             state_q, state_d;
    logic signed [63:0] arg_q, arg_d;
    logic signed [31:0] dist_q, dist_d;
    logic [4:0]         idx_q, idx_d;
    logic               neg_q, neg_d;
    logic               skip_q, skip_d;
    logic signed [63:0] xp_q, xp_d;
    logic signed [63:0] yp_q, yp_d;
    logic               done_q, done_d;
    logic               rerr_q, rerr_d;

    logic               load, step;
    logic signed [63:0] a_fix, a_red, z0, x0;
    logic               a_ok, q_neg;
    logic signed [63:0] cx, cy, dx, dy;

    // Single wrap correction, then fold into [-pi/2, pi/2]
    always_comb begin
        if (arg_q < 64'sd0)
            a_fix = arg_q + TWO_PI_MICRO;
        else if (arg_q >= TWO_PI_MICRO)
            a_fix = arg_q - TWO_PI_MICRO;
        else
            a_fix = arg_q;
        a_ok  = (a_fix >= 64'sd0) && (a_fix < TWO_PI_MICRO);
        a_red = (a_fix > PI_MICRO) ? a_fix - TWO_PI_MICRO : a_fix;
        q_neg = 1'b1;
        if (a_red > HALF_PI_MICRO)
            z0 = a_red - PI_MICRO;
        else if (a_red < -HALF_PI_MICRO)
            z0 = a_red + PI_MICRO;
        else begin
            z0    = a_red;
            q_neg = 1'b0;
        end
        x0 = 64'(dist_q) * CORDIC_GAIN_Q16;
    end

    always_comb begin
        dx = cx >>> FRAC_BITS;
        dy = cy >>> FRAC_BITS;
        if (neg_q) begin
            dx = -dx;
            dy = -dy;
        end
    end

    cordic_rotator u_cordic (
        .clk    (clk),
        .reset  (reset),
        .load_i (load),
        .step_i (step),
        .idx_i  (idx_q),
        .x0_i   (x0),
        .y0_i   (64'sd0),
        .z0_i   (z0),
        .x_o    (cx),
        .y_o    (cy)
    );

    always_comb begin
        state_d = state_q;
        arg_d   = arg_q;
        dist_d  = dist_q;
        idx_d   = idx_q;
        neg_d   = neg_q;
        skip_d  = skip_q;
        xp_d    = xp_q;
        yp_d    = yp_q;
        done_d  = 1'b0;
        rerr_d  = 1'b0;
        load    = 1'b0;
        step    = 1'b0;
        if (clear_pos) begin
            state_d = IDLE;
            xp_d    = '0;
            yp_d    = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        arg_d   = argument;
                        dist_d  = delta_dist;
                        state_d = PREP;
                    end
                end
                PREP: begin
                    load    = 1'b1;
                    idx_d   = '0;
                    neg_d   = q_neg;
                    skip_d  = !a_ok;
                    state_d = ITER;
                end
                ITER: begin
                    step  = 1'b1;
                    idx_d = idx_q + 5'd1;
                    if (idx_q == 5'(ITERATIONS - 1))
                        state_d = ACC;
                end
                ACC: begin
                    done_d  = 1'b1;
                    rerr_d  = skip_q;
                    state_d = IDLE;
                    if (!skip_q) begin
                        xp_d = xp_q + dx;
                        yp_d = yp_q + dy;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            arg_q   <= '0;
            dist_q  <= '0;
            idx_q   <= '0;
            neg_q   <= 1'b0;
            skip_q  <= 1'b0;
            xp_q    <= '0;
            yp_q    <= '0;
            done_q  <= 1'b0;
            rerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            arg_q   <= arg_d;
            dist_q  <= dist_d;
            idx_q   <= idx_d;
            neg_q   <= neg_d;
            skip_q  <= skip_d;
            xp_q    <= xp_d;
            yp_q    <= yp_d;
            done_q  <= done_d;
            rerr_q  <= rerr_d;
        end
    end

    assign x_pos     = xp_q;
    assign y_pos     = yp_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign range_err = rerr_q;

endmodule
